view_ctrl: RTL and testbench



---
 rtl/view_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_view_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/view_ctrl.sv
// Viewport controller: turns held pan/zoom buttons into frame-synchronous
// shift_x/shift_y/scroll updates, committed atomically once per frame.
module view_ctrl #(
    parameter int P_PARAM_N    = 1024,
    parameter int P_PARAM_M    = 1024,
    parameter int HSIZE        = 800,
    parameter int VSIZE        = 600,
    parameter int MAX_SCROLL   = 4,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_zoom_in,
    input  logic        btn_zoom_out,
    input  logic        recenter,
    output logic [15:0] shift_x,
    output logic [15:0] shift_y,
    output logic [3:0]  scroll,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ZOOM, PAN, CLAMP, COMMIT} state_t;

    localparam int NB     = 6;
    localparam int I_UP   = 0;
    localparam int I_DOWN = 1;
    localparam int I_LEFT = 2;
    localparam int I_RGHT = 3;
    localparam int I_ZIN  = 4;
    localparam int I_ZOUT = 5;

    localparam int CW = $clog2(REPEAT_DELAY + 1);
    localparam logic [CW-1:0] CNT_DELAY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(REPEAT_DELAY - REPEAT_RATE + 1);

    function automatic logic signed [17:0] vis_w(input logic [3:0] s);
        return 18'(HSIZE >> s);
    endfunction

    function automatic logic signed [17:0] vis_h(input logic [3:0] s);
        return 18'(VSIZE >> s);
    endfunction

    function automatic logic signed [17:0] max_x(input logic [3:0] s);
        int m;
        m = P_PARAM_N - (HSIZE >> s);
        return (m < 0) ? '0 : 18'(m);
    endfunction

    function automatic logic signed [17:0] max_y(input logic [3:0] s);
        int m;
        m = P_PARAM_M - (VSIZE >> s);
        return (m < 0) ? '0 : 18'(m);
    endfunction

    function automatic logic signed [17:0] step(input logic [3:0] s);
        return 18'(1 << (MAX_SCROLL - int'(s)));
    endfunction

    function automatic logic signed [17:0] clamp(input logic signed [17:0] v,
                                                 input logic signed [17:0] hi);
        if (v < 0) return '0;
        if (v > hi) return hi;
        return v;
    endfunction

    state_t state, state_nxt;

    logic [NB-1:0]        btn, fire, fired;
    logic [CW-1:0]        cnt [NB];
    logic                 rec_fired, skip_pan, start;
    logic signed [17:0]   wx, wy, dx, dy, st;
    logic signed [17:0]   zin_dx, zin_dy, zout_dx, zout_dy;
    logic [3:0]           ws, ws_up, ws_dn;
    logic                 zoom_in_ok, zoom_out_ok;

    // NOTE: every signal driven here gets a value before any branch, so no latch can form.
    always_comb begin
        btn   = {btn_zoom_out, btn_zoom_in, btn_right, btn_left, btn_down, btn_up};
        start = (state == IDLE) && frame_start;
        fire  = '0;
        for (int i = 0; i < NB; i++)
            fire[i] = btn[i] && (cnt[i] == '0 || cnt[i] == CNT_DELAY);

        ws_up   = ws + 4'd1;
        ws_dn   = ws - 4'd1;
        zin_dx  = (vis_w(ws) - vis_w(ws_up)) >>> 1;
        zin_dy  = (vis_h(ws) - vis_h(ws_up)) >>> 1;
        zout_dx = (vis_w(ws_dn) - vis_w(ws)) >>> 1;
        zout_dy = (vis_h(ws_dn) - vis_h(ws)) >>> 1;
        zoom_in_ok  = fired[I_ZIN] && !fired[I_ZOUT] && (int'(ws) < MAX_SCROLL);
        zoom_out_ok = fired[I_ZOUT] && !fired[I_ZIN] && (ws != 4'd0);

        // Opposite directions on one axis cancel because both terms apply.
        st = step(ws);
        dx = (fired[I_RGHT] ? st : 18'sd0) - (fired[I_LEFT] ? st : 18'sd0);
        dy = (fired[I_DOWN] ? st : 18'sd0) - (fired[I_UP]   ? st : 18'sd0);
    end

    // Per-button hold counters; reaching REPEAT_DELAY fires and reloads so the
    // next fire follows REPEAT_RATE frames later, keeping the count bounded.
    // NOTE: these are a handful of flops, not a RAM, so reset clears every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else if (start) begin
            for (int i = 0; i < NB; i++) begin
                if (!btn[i])                cnt[i] <= '0;
                else if (cnt[i] == CNT_DELAY) cnt[i] <= CNT_RELOAD;
                else                        cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = ZOOM;
            ZOOM:    state_nxt = PAN;
            PAN:     state_nxt = CLAMP;
            CLAMP:   state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working copy of the view; the visible registers only move in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wx        <= '0;
            wy        <= '0;
            ws        <= '0;
            fired     <= '0;
            rec_fired <= 1'b0;
            skip_pan  <= 1'b0;
            shift_x   <= '0;
            shift_y   <= '0;
            scroll    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (frame_start) begin
                    fired     <= fire;
                    rec_fired <= recenter;
                    wx        <= $signed({2'b00, shift_x});
                    wy        <= $signed({2'b00, shift_y});
                    ws        <= scroll;
                    skip_pan  <= 1'b0;
                    busy      <= 1'b1;
                end
                ZOOM: begin
                    if (rec_fired) begin
                        wx       <= '0;
                        wy       <= '0;
                        ws       <= '0;
                        skip_pan <= 1'b1;
                    end else if (zoom_in_ok) begin
                        wx       <= wx + zin_dx;
                        wy       <= wy + zin_dy;
                        ws       <= ws_up;
                        skip_pan <= 1'b1;
                    end else if (zoom_out_ok) begin
                        wx       <= wx - zout_dx;
                        wy       <= wy - zout_dy;
                        ws       <= ws_dn;
                        skip_pan <= 1'b1;
                    end
                end
                PAN: if (!skip_pan) begin
                    wx <= wx + dx;
                    wy <= wy + dy;
                end
                CLAMP: begin
                    wx <= clamp(wx, max_x(ws));
                    wy <= clamp(wy, max_y(ws));
                end
                COMMIT: begin
                    shift_x <= wx[15:0];
                    shift_y <= wy[15:0];
                    scroll  <= ws;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_view_ctrl.sv
// Directed self-checking bench for view_ctrl with hand-computed viewport values.
module tb_view_ctrl;

    localparam logic [6:0] B_R  = 7'b0000001;
    localparam logic [6:0] B_L  = 7'b0000010;
    localparam logic [6:0] B_D  = 7'b0000100;
    localparam logic [6:0] B_U  = 7'b0001000;
    localparam logic [6:0] B_ZI = 7'b0010000;
    localparam logic [6:0] B_ZO = 7'b0100000;
    localparam logic [6:0] B_RC = 7'b1000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        btn_zoom_in = 1'b0, btn_zoom_out = 1'b0, recenter = 1'b0;
    logic [15:0] shift_x, shift_y;
    logic [3:0]  scroll;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    view_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_zoom_in  (btn_zoom_in),
        .btn_zoom_out (btn_zoom_out),
        .recenter     (recenter),
        .shift_x      (shift_x),
        .shift_y      (shift_y),
        .scroll       (scroll),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_view(input string tag, input int x, input int y, input int s);
        check({tag, ".x"}, 32'(shift_x), x);
        check({tag, ".y"}, 32'(shift_y), y);
        check({tag, ".s"}, 32'(scroll), s);
        check({tag, ".busy"}, 32'(busy), 0);
    endtask

    task automatic set_btns(input logic [6:0] b);
        {recenter, btn_zoom_out, btn_zoom_in, btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    // One frame: pulse frame_start, then wait past the commit edge.
    task automatic frame(input logic [6:0] b);
        @(negedge clk);
        set_btns(b);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse(input logic [6:0] b);
        frame(b);
        frame(7'b0);
    endtask

    initial begin
        int exp_x, exp_y, falls;
        logic prev_busy;

        // Reset state
        repeat (3) @(negedge clk);
        check_view("reset", 0, 0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: hold right; fires at frame 0, then 20, 24, ... ; clamps at 224
        exp_x = 0;
        for (int k = 0; k < 80; k++) begin
            frame(B_R);
            if (k == 0 || (k >= 20 && (k - 20) % 4 == 0))
                exp_x = (exp_x + 16 > 224) ? 224 : exp_x + 16;
            check($sformatf("hold_right[%0d].x", k), 32'(shift_x), exp_x);
        end
        check("hold_right.final", 32'(shift_x), 224);
        frame(7'b0);
        check_view("idle_frame", 224, 0, 0);
        pulse(B_RC);
        check_view("recenter0", 0, 0, 0);

        // 2: zoom in with exact latency
        @(negedge clk);
        set_btns(B_ZI);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check("zin.lat.busy", 32'(busy), 1);
        check("zin.lat.s_old", 32'(scroll), 0);
        check("zin.lat.x_old", 32'(shift_x), 0);
        @(negedge clk);
        check_view("zin", 200, 150, 1);
        repeat (2) @(negedge clk);
        frame(7'b0);
        check_view("zin.hold", 200, 150, 1);

        // 3: zoom out floors at 0, limits at both ends
        pulse(B_L);
        check_view("pan_left_s1", 192, 150, 1);
        pulse(B_ZO);
        check_view("zout_floor", 0, 0, 0);
        pulse(B_ZO);
        check_view("zout_at_min", 0, 0, 0);
        pulse(B_ZI);
        check_view("zin_s1", 200, 150, 1);
        pulse(B_ZI);
        check_view("zin_s2", 300, 225, 2);
        pulse(B_ZI);
        check_view("zin_s3", 350, 262, 3);
        pulse(B_ZI);
        check_view("zin_s4", 375, 281, 4);
        pulse(B_ZI);
        check_view("zin_at_max", 375, 281, 4);
        pulse(B_ZI | B_ZO);
        check_view("zin_zout_both", 375, 281, 4);

        // 4: left+right cancel, down steps by 4 at scroll 2
        pulse(B_RC);
        pulse(B_ZI);
        pulse(B_ZI);
        check_view("s2_start", 300, 225, 2);
        exp_y = 225;
        for (int k = 0; k < 25; k++) begin
            frame(B_L | B_R | B_D);
            if (k == 0 || (k >= 20 && (k - 20) % 4 == 0)) exp_y += 4;
            check($sformatf("diag[%0d].x", k), 32'(shift_x), 300);
            check($sformatf("diag[%0d].y", k), 32'(shift_y), exp_y);
        end
        frame(7'b0);
        check_view("diag_end", 300, 237, 2);

        // 5: zoom has priority over pan, then recenter
        pulse(B_ZI | B_U);
        check_view("zoom_prio", 350, 274, 3);
        pulse(B_RC);
        check_view("recenter", 0, 0, 0);

        // 6: reset mid-update aborts, frame_start while busy is ignored
        pulse(B_ZI);
        check_view("pre_abort", 200, 150, 1);
        @(negedge clk);
        set_btns(B_R);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("abort.busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_view("abort.in_reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_view("abort.after", 0, 0, 0);

        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        prev_busy = busy;
        falls = 0;
        @(negedge clk);
        frame_start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (prev_busy && !busy) falls++;
            prev_busy = busy;
            @(negedge clk);
        end
        check("busy_fs.commits", 32'(falls), 1);
        check_view("busy_fs", 16, 0, 0);
        frame(7'b0);
        check_view("busy_fs.idle", 16, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
